ripple_cntr_monitor: RTL

Downstream consumer of the 3-bit T-flip-flop ripple counter. Its fQ outputs are asynchronous to the system clock and glitch during ripple transitions. This block synchronizes and filters that count into the system clock domain, extends it to a wide synchronous count and flags wrap-around. It also detects illegal (non +1) steps caused by missed events or corruption.

---
 rtl/ripple_cntr_monitor_pkg.sv | 20 ++
 rtl/ripple_cntr_monitor_if.sv | 24 ++
 rtl/ripple_cntr_monitor_sync_filter.sv | 45 ++++
 rtl/ripple_cntr_monitor.sv | 98 +++++++++
 4 files changed

// File: rtl/ripple_cntr_monitor_pkg.sv
// Shared encodings for the ripple counter monitor: FSM states, ripple width,
// and the modulo-8 successor test used to classify steps.
package ripple_mon_pkg;

  localparam int          RIPPLE_W   = 3;
  localparam logic [2:0]  RIPPLE_MAX = 3'd7;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_e;

  // Legal ripple step: new value is the old one plus one, wrapping 7 -> 0.
  function automatic logic is_next(input logic [RIPPLE_W-1:0] cur,
                                   input logic [RIPPLE_W-1:0] nxt);
    return nxt == (cur + RIPPLE_W'(1));
  endfunction

endpackage

// File: rtl/ripple_cntr_monitor_if.sv
// Control/observation bundle between the ripple monitor and its consumer.
interface ripple_cntr_monitor_if #(parameter int EXT_W = 16);
  import ripple_mon_pkg::*;

  logic                clr;
  logic [RIPPLE_W-1:0] ripple_q;
  logic [RIPPLE_W-1:0] filt_q;
  logic [EXT_W-1:0]    ext_cnt;
  logic                ext_valid;
  logic                tick;
  logic                skip_err;
  logic [1:0]          state;

  modport master (
    output clr, ripple_q,
    input  filt_q, ext_cnt, ext_valid, tick, skip_err, state
  );

  modport slave (
    input  clr, ripple_q,
    output filt_q, ext_cnt, ext_valid, tick, skip_err, state
  );

endinterface

// File: rtl/ripple_cntr_monitor_sync_filter.sv
// Two-flop synchronizer plus a stability filter: a value must persist for
// STABLE_CYC synchronized samples before it is published with a 1-cycle strobe.
module ripple_sync_filter #(
  parameter int W          = 3,
  parameter int STABLE_CYC = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] fval,
  output logic         acc
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  logic [1:0][W-1:0] sync;
  logic [W-1:0]      cand;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      cand <= '0;
      cnt  <= '0;
      fval <= '0;
      acc  <= 1'b0;
    end else begin
      sync[0] <= raw;
      sync[1] <= sync[0];
      // Any change restarts the run; the count saturates once stable.
      if (sync[1] != cand) begin
        cand <= sync[1];
        cnt  <= CW'(1);
      end else if (cnt < CW'(STABLE_CYC)) begin
        cnt <= cnt + CW'(1);
      end
      acc <= 1'b0;
      if (cnt == CW'(STABLE_CYC) && cand != fval) begin
        fval <= cand;
        acc  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ripple_cntr_monitor.sv
// Ripple counter monitor: filters the asynchronous 3-bit count, extends it to
// EXT_W bits, pulses tick on ripple wrap and flags illegal steps.
module ripple_cntr_monitor
  import ripple_mon_pkg::*;
#(
  parameter int EXT_W      = 16,
  parameter int STABLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  ripple_cntr_monitor_if.slave  bus
);

  logic [RIPPLE_W-1:0] fval;
  logic                acc;

  ripple_sync_filter #(
    .W          (RIPPLE_W),
    .STABLE_CYC (STABLE_CYC)
  ) u_filt (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.ripple_q),
    .fval  (fval),
    .acc   (acc)
  );

  mon_state_e          st, st_nx;
  logic [RIPPLE_W-1:0] filt, filt_nx;
  logic [EXT_W-1:0]    ext, ext_nx;
  logic                tick_r, tick_nx;
  logic                skip, skip_nx;
  logic                pend, pend_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= SYNC;
      filt   <= '0;
      ext    <= '0;
      tick_r <= 1'b0;
      skip   <= 1'b0;
      pend   <= 1'b0;
    end else begin
      st     <= st_nx;
      filt   <= filt_nx;
      ext    <= ext_nx;
      tick_r <= tick_nx;
      skip   <= skip_nx;
      pend   <= pend_nx;
    end
  end

  always_comb begin
    st_nx   = st;
    filt_nx = acc ? fval : filt;
    ext_nx  = ext;
    tick_nx = 1'b0;
    skip_nx = skip;
    pend_nx = pend;
    if (bus.clr) begin
      st_nx   = SYNC;
      ext_nx  = '0;
      skip_nx = 1'b0;
      // An event swallowed by clr still serves as the next baseline.
      pend_nx = acc;
    end else begin
      unique case (st)
        SYNC: begin
          if (acc || pend) begin
            st_nx   = TRACK;
            pend_nx = 1'b0;
          end
        end
        TRACK: begin
          if (acc) begin
            if (is_next(filt, fval)) begin
              ext_nx  = ext + EXT_W'(1);
              tick_nx = (filt == RIPPLE_MAX);
            end else begin
              skip_nx = 1'b1;
              st_nx   = FAULT;
            end
          end
        end
        FAULT: ;
        default: st_nx = SYNC;
      endcase
    end
  end

  assign bus.filt_q    = filt;
  assign bus.ext_cnt   = ext;
  assign bus.ext_valid = (st == TRACK);
  assign bus.tick      = tick_r;
  assign bus.skip_err  = skip;
  assign bus.state     = st;

endmodule
